tx_control: RTL and testbench

- Device-to-host counterpart of the receive-side control/memory path.
- On a start request, reads a block of bytes from the main byte memory and streams it to the host over the UART transmitter.
- Each block is framed as a 2-byte big-endian length header followed by the payload bytes.
- Sits between the memory read port (readPtr/outData) and the async_transmitter (TxD_start/TxD_data/TxD_busy) inside comm.

---
 rtl/tx_control_if.sv | 40 ++++
 rtl/tx_control.sv | 155 +++++++++++++++
 tb/tb_tx_control.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_control_if.sv
// tx_control_if: groups the memory read port, transmitter handshake and
// request/status lines of tx_control into one bundle.
//
// Signal summary:
//   device2host  start request (host side -> tx_control)
//   base_addr    first memory address of the block
//   byte_count   number of payload bytes in the block
//   readPtr      memory read address (tx_control -> memory)
//   rdata        memory read data, valid RD_LAT clocks after readPtr
//   TxD_start    one-cycle load pulse to the UART transmitter
//   TxD_data     byte presented to the transmitter
//   TxD_busy     transmitter busy
//   busy         transfer in progress
//   done         one-cycle pulse once the last byte has left the transmitter
//
// Modports: slave = tx_control itself, master = the surrounding logic.
interface tx_control_if #(
    parameter int ADDR_W = 16
);
    logic              device2host;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] byte_count;
    logic [ADDR_W-1:0] readPtr;
    logic [7:0]        rdata;
    logic              TxD_start;
    logic [7:0]        TxD_data;
    logic              TxD_busy;
    logic              busy;
    logic              done;

    modport slave (
        input  device2host, base_addr, byte_count, rdata, TxD_busy,
        output readPtr, TxD_start, TxD_data, busy, done
    );

    modport master (
        output device2host, base_addr, byte_count, rdata, TxD_busy,
        input  readPtr, TxD_start, TxD_data, busy, done
    );
endinterface

// File: rtl/tx_control.sv
// tx_control: on a start request, reads a block of bytes from the byte
// memory and streams it to the host through the UART transmitter, framed
// as a 2-byte big-endian length header followed by the payload.
//
// Ports:
//   clk      system clock
//   reset    synchronous, active-high reset
//   bus      tx_control_if.slave (request, memory read port, transmitter)
//   state_o  debug view of the FSM state:
//            0 IDLE, 1 HDR_HI, 2 HDR_LO, 3 FETCH, 4 WAIT_RD, 5 SEND,
//            6 WAIT_TX, 7 FINISH
//
// Transmitter handshake: a byte is handed over by a one-cycle TxD_start
// pulse with TxD_data valid in the same cycle, and only when TxD_busy was
// low in the cycle before. The transmitter raises TxD_busy the cycle after
// it sees TxD_start and drops it once the frame has left the line.
module tx_control #(
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    tx_control_if.slave    bus,
    output logic [2:0]     state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR_HI  = 3'd1,
        HDR_LO  = 3'd2,
        FETCH   = 3'd3,
        WAIT_RD = 3'd4,
        SEND    = 3'd5,
        WAIT_TX = 3'd6,
        FINISH  = 3'd7
    } state_e;

    localparam logic [1:0] LAT_INIT = 2'(RD_LAT);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [1:0]        lat_q, lat_d;
    logic              from_hi_q, from_hi_d;   // last byte sent was the high header byte
    logic              start_q, start_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        hdr_hi, hdr_lo;

    // Header bytes of the block length; bits beyond ADDR_W read as zero.
    always_comb begin
        hdr_hi = 8'h00;
        hdr_lo = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (i < ADDR_W)     hdr_lo[i] = rem_q[i];
            if (i + 8 < ADDR_W) hdr_hi[i] = rem_q[i + 8];
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            rem_q     <= '0;
            lat_q     <= '0;
            from_hi_q <= 1'b0;
            start_q   <= 1'b0;
            data_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            lat_q     <= lat_d;
            from_hi_q <= from_hi_d;
            start_q   <= start_d;
            data_q    <= data_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.device2host) state_d = HDR_HI;
            HDR_HI,
            HDR_LO,
            SEND:    if (!bus.TxD_busy) state_d = WAIT_TX;
            FETCH:   state_d = WAIT_RD;
            WAIT_RD: if (lat_q == 2'd1) state_d = SEND;
            // start_q is high exactly in the first WAIT_TX cycle, when the
            // transmitter has not yet had a chance to raise TxD_busy.
            WAIT_TX: begin
                if (!start_q && !bus.TxD_busy) begin
                    if (from_hi_q)         state_d = HDR_LO;
                    else if (rem_q != '0)  state_d = FETCH;
                    else                   state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        lat_d     = lat_q;
        from_hi_d = from_hi_q;
        start_d   = 1'b0;
        data_d    = data_q;
        case (state_q)
            IDLE: begin
                if (bus.device2host) begin
                    ptr_d = bus.base_addr;
                    rem_d = bus.byte_count;
                end
            end
            HDR_HI: begin
                if (!bus.TxD_busy) begin
                    data_d    = hdr_hi;
                    start_d   = 1'b1;
                    from_hi_d = 1'b1;
                end
            end
            HDR_LO: begin
                if (!bus.TxD_busy) begin
                    data_d    = hdr_lo;
                    start_d   = 1'b1;
                    from_hi_d = 1'b0;
                end
            end
            FETCH:   lat_d = LAT_INIT;
            WAIT_RD: lat_d = lat_q - 2'd1;
            SEND: begin
                if (!bus.TxD_busy) begin
                    data_d    = bus.rdata;
                    start_d   = 1'b1;
                    from_hi_d = 1'b0;
                    ptr_d     = ptr_q + ADDR_W'(1);
                    rem_d     = rem_q - ADDR_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign bus.readPtr   = ptr_q;
    assign bus.TxD_start = start_q;
    assign bus.TxD_data  = data_q;
    assign bus.busy      = (state_q != IDLE) && (state_q != FINISH);
    assign bus.done      = (state_q == FINISH);
    assign state_o       = state_q;

endmodule

// File: tb/tb_tx_control.sv
// tb_tx_control: runs an RD_LAT=1 and an RD_LAT=2 instance of tx_control
// side by side on identical requests, each with its own memory read
// pipeline and transmitter model, and compares the transmitted byte stream
// against a framing model built from the memory contents.
module tb_tx_control;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          d2h;
    logic [AW-1:0] base;
    logic [AW-1:0] cnt;
    logic [2:0]    st0, st1;
    int            tx_cyc;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tx_control_if #(.ADDR_W(AW)) if0 ();
    tx_control_if #(.ADDR_W(AW)) if1 ();

    tx_control #(.ADDR_W(AW), .RD_LAT(1)) dut0 (
        .clk(clk), .reset(reset), .bus(if0.slave), .state_o(st0)
    );
    tx_control #(.ADDR_W(AW), .RD_LAT(2)) dut1 (
        .clk(clk), .reset(reset), .bus(if1.slave), .state_o(st1)
    );

    assign if0.device2host = d2h;
    assign if1.device2host = d2h;
    assign if0.base_addr   = base;
    assign if1.base_addr   = base;
    assign if0.byte_count  = cnt;
    assign if1.byte_count  = cnt;

    // Byte memory with 1- and 2-cycle read pipelines.
    logic [7:0] mem [0:65535];
    logic [7:0] p1;
    always @(posedge clk) begin
        if0.rdata <= mem[if0.readPtr];
        p1        <= mem[if1.readPtr];
        if1.rdata <= p1;
    end

    // Transmitter models: busy for tx_cyc cycles starting the cycle after a start.
    int tx_cnt0 = 0;
    int tx_cnt1 = 0;
    always @(posedge clk) begin
        if (if0.TxD_start === 1'b1) tx_cnt0 <= tx_cyc;
        else if (tx_cnt0 != 0)      tx_cnt0 <= tx_cnt0 - 1;
        if (if1.TxD_start === 1'b1) tx_cnt1 <= tx_cyc;
        else if (tx_cnt1 != 0)      tx_cnt1 <= tx_cnt1 - 1;
    end
    assign if0.TxD_busy = (tx_cnt0 != 0);
    assign if1.TxD_busy = (tx_cnt1 != 0);

    // Monitors: capture bytes, count pulses and handshake violations.
    logic [7:0] got0_q[$];
    logic [7:0] got1_q[$];
    int starts0 = 0, starts1 = 0, dones0 = 0, dones1 = 0, viol0 = 0, viol1 = 0;
    logic prev0 = 1'b0, prev1 = 1'b0;
    always @(posedge clk) begin
        if (if0.TxD_start === 1'b1) begin
            got0_q.push_back(if0.TxD_data);
            starts0++;
            if (if0.TxD_busy || prev0) viol0++;
        end
        if (if1.TxD_start === 1'b1) begin
            got1_q.push_back(if1.TxD_data);
            starts1++;
            if (if1.TxD_busy || prev1) viol1++;
        end
        if (if0.done === 1'b1) dones0++;
        if (if1.done === 1'b1) dones1++;
        prev0 <= (if0.TxD_start === 1'b1);
        prev1 <= (if1.TxD_start === 1'b1);
    end

    // Scoreboard expectation: length header then the memory block.
    logic [7:0] exp_q[$];

    task automatic build_exp(input logic [AW-1:0] b, input logic [AW-1:0] c);
        logic [AW-1:0] a;
        exp_q.delete();
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[7:0]);
        for (int i = 0; i < int'(c); i++) begin
            a = b + AW'(i);
            exp_q.push_back(mem[a]);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_bytes(input string tag, input int g0, input int g1, input int n);
        logic [7:0] v0, v1;
        for (int i = 0; i < n; i++) begin
            v0 = (g0 + i < got0_q.size()) ? got0_q[g0 + i] : 8'hxx;
            v1 = (g1 + i < got1_q.size()) ? got1_q[g1 + i] : 8'hxx;
            check($sformatf("%s lat1 byte%0d", tag, i), 32'(v0), 32'(exp_q[i]));
            check($sformatf("%s lat2 byte%0d", tag, i), 32'(v1), 32'(exp_q[i]));
        end
    endtask

    task automatic run_xfer(input logic [AW-1:0] b, input logic [AW-1:0] c,
                            input bit mid_req, input string tag);
        int g0, g1, s0, s1, d0, d1, v0, v1, budget;
        bit ok;
        g0 = got0_q.size(); g1 = got1_q.size();
        s0 = starts0; s1 = starts1; d0 = dones0; d1 = dones1; v0 = viol0; v1 = viol1;
        build_exp(b, c);
        base = b;
        cnt  = c;
        d2h  = 1'b1;
        @(posedge clk); #1;
        d2h  = 1'b0;
        base = AW'($urandom);
        cnt  = AW'($urandom);
        @(posedge clk); #1;
        check({tag, " lat1 busy"}, 32'(if0.busy), 32'd1);
        check({tag, " lat2 busy"}, 32'(if1.busy), 32'd1);
        budget = (int'(c) + 2) * (tx_cyc + 8) + 100;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (mid_req && k == 15) d2h = 1'b1;
            if (k == 16) d2h = 1'b0;
            @(posedge clk); #1;
            if (dones0 != d0 && dones1 != d1) begin
                ok = 1'b1;
                break;
            end
        end
        d2h = 1'b0;
        check({tag, " completion"}, 32'(ok), 32'd1);
        repeat (tx_cyc + 10) @(posedge clk);
        #1;
        check({tag, " lat1 starts"}, 32'(starts0 - s0), 32'(int'(c) + 2));
        check({tag, " lat2 starts"}, 32'(starts1 - s1), 32'(int'(c) + 2));
        check({tag, " lat1 dones"}, 32'(dones0 - d0), 32'd1);
        check({tag, " lat2 dones"}, 32'(dones1 - d1), 32'd1);
        check({tag, " lat1 handshake"}, 32'(viol0 - v0), 32'd0);
        check({tag, " lat2 handshake"}, 32'(viol1 - v1), 32'd0);
        check({tag, " lat1 busy end"}, 32'(if0.busy), 32'd0);
        check({tag, " lat2 busy end"}, 32'(if1.busy), 32'd0);
        check({tag, " lat1 idle"}, 32'(st0), 32'd0);
        check({tag, " lat2 idle"}, 32'(st1), 32'd0);
        check({tag, " lat1 readPtr"}, 32'(if0.readPtr), 32'(AW'(b + c)));
        check({tag, " lat2 readPtr"}, 32'(if1.readPtr), 32'(AW'(b + c)));
        check_bytes(tag, g0, g1, exp_q.size());
    endtask

    task automatic run_reset_abort();
        int g0, s0, s1, d0, d1;
        logic [AW-1:0] b;
        bit ok;
        tx_cyc = 20;
        b = AW'($urandom);
        g0 = got0_q.size();
        build_exp(b, AW'(10));
        base = b;
        cnt  = AW'(10);
        d2h  = 1'b1;
        @(posedge clk); #1;
        d2h  = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            if (got0_q.size() - g0 >= 5) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort reach 3rd payload", 32'(ok), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort lat1 state", 32'(st0), 32'd0);
        check("abort lat1 busy", 32'(if0.busy), 32'd0);
        check("abort lat1 start", 32'(if0.TxD_start), 32'd0);
        check("abort lat1 readPtr", 32'(if0.readPtr), 32'd0);
        check("abort lat2 state", 32'(st1), 32'd0);
        check("abort lat2 readPtr", 32'(if1.readPtr), 32'd0);
        reset = 1'b0;
        check_bytes("abort", g0, got1_q.size(), 0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("abort lat1 byte%0d", i), 32'(got0_q[g0 + i]), 32'(exp_q[i]));
        end
        s0 = starts0; s1 = starts1; d0 = dones0; d1 = dones1;
        repeat (40) @(posedge clk);
        #1;
        check("abort lat1 quiet starts", 32'(starts0 - s0), 32'd0);
        check("abort lat2 quiet starts", 32'(starts1 - s1), 32'd0);
        check("abort lat1 no done", 32'(dones0 - d0), 32'd0);
        check("abort lat2 no done", 32'(dones1 - d1), 32'd0);
        run_xfer(AW'($urandom), AW'(3), 1'b0, "post_reset");
    endtask

    initial begin
        reset  = 1'b1;
        d2h    = 1'b0;
        base   = '0;
        cnt    = '0;
        tx_cyc = 20;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check("reset lat1 state", 32'(st0), 32'd0);
        check("reset lat1 busy", 32'(if0.busy), 32'd0);
        check("reset lat1 done", 32'(if0.done), 32'd0);
        check("reset lat1 start", 32'(if0.TxD_start), 32'd0);
        check("reset lat1 data", 32'(if0.TxD_data), 32'd0);
        check("reset lat1 readPtr", 32'(if0.readPtr), 32'd0);
        check("reset lat2 state", 32'(st1), 32'd0);
        check("reset lat2 readPtr", 32'(if1.readPtr), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        mem[16'h0010] = 8'hA5;
        mem[16'h0011] = 8'h3C;
        mem[16'h0012] = 8'hFF;
        run_xfer(16'h0010, 16'd3, 1'b0, "basic");
        run_xfer(16'h1234, 16'd0, 1'b0, "empty");
        mem[16'hFFFF] = 8'h11;
        mem[16'h0000] = 8'h22;
        run_xfer(16'hFFFF, 16'd2, 1'b0, "wrap");
        tx_cyc = 20;
        run_xfer(AW'($urandom), AW'($urandom_range(3, 6)), 1'b1, "mid_request");
        run_reset_abort();
        for (int r = 0; r < 6; r++) begin
            tx_cyc = $urandom_range(1, 8);
            run_xfer(AW'($urandom), AW'($urandom_range(0, 12)), 1'b0,
                     $sformatf("rand%0d", r));
        end
        tx_cyc = 2;
        run_xfer(16'h0100, 16'd300, 1'b0, "long_hdr");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
